// File: rtl/dmem_arbiter.sv
// Single-port data RAM sequencer shared by fetch (F), load (L) and store (S).
// Fixed priority S > L > F with a starvation guard for F; all outputs registered.
module dmem_arbiter #(
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iREQ_F,
  input  logic        iREQ_L,
  input  logic        iREQ_S,
  input  logic [7:0]  iADDR_F,
  input  logic [7:0]  iADDR_L,
  input  logic [7:0]  iADDR_S,
  input  logic [31:0] iWDATA_S,
  output logic        oDONE_F,
  output logic        oDONE_L,
  output logic        oDONE_S,
  output logic [31:0] oRDATA,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [7:0]  oRAM_ADDR,
  output logic [31:0] oRAM_DATA_WR,
  input  logic [31:0] iRAM_DATA_RD,
  output logic        oBUSY
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [2:0]    LAT_LAST   = 3'(RAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_L, OWN_S} owner_t;

  state_t        state, state_d;
  owner_t        owner, owner_d, win;
  logic [2:0]    lat_cnt, lat_d;
  logic [SW-1:0] starve_cnt, starve_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic        ce_d, rd_d, wr_d, busy_d;
  logic        done_f_d, done_l_d, done_s_d;
  logic [7:0]  ram_addr_d;
  logic [31:0] ram_wdata_d, rdata_d;

  // Next-state logic computes the value every output takes after the edge,
  // so the RAM controls and DONE pulses come straight from flops.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    lat_d       = lat_cnt;
    starve_d    = starve_cnt;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ce_d        = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    done_f_d    = 1'b0;
    done_l_d    = 1'b0;
    done_s_d    = 1'b0;
    rdata_d     = oRDATA;
    win         = OWN_NONE;

    unique case (state)
      IDLE: begin
        if (iREQ_F && starve_cnt == STARVE_TOP) win = OWN_F;
        else if (iREQ_S)                        win = OWN_S;
        else if (iREQ_L)                        win = OWN_L;
        else if (iREQ_F)                        win = OWN_F;

        if (!iREQ_F || win == OWN_F)            starve_d = '0;
        else if (starve_cnt != STARVE_TOP)      starve_d = starve_cnt + 1'b1;

        if (win != OWN_NONE) begin
          state_d = ACCESS;
          owner_d = win;
          lat_d   = '0;
          ce_d    = 1'b1;
          case (win)
            OWN_S: begin
              addr_d      = iADDR_S;
              wdata_d     = iWDATA_S;
              wr_d        = 1'b1;
              ram_wdata_d = iWDATA_S;
            end
            OWN_L: begin
              addr_d = iADDR_L;
              rd_d   = 1'b1;
            end
            default: begin
              addr_d = iADDR_F;
              rd_d   = 1'b1;
            end
          endcase
          ram_addr_d = addr_d;
        end
      end

      ACCESS: begin
        if (lat_cnt == LAT_LAST) begin
          state_d  = DONE;
          lat_d    = '0;
          done_f_d = (owner == OWN_F);
          done_l_d = (owner == OWN_L);
          done_s_d = (owner == OWN_S);
          if (owner == OWN_F || owner == OWN_L) rdata_d = iRAM_DATA_RD;
        end else begin
          lat_d       = lat_cnt + 3'd1;
          ce_d        = 1'b1;
          rd_d        = (owner != OWN_S);
          wr_d        = (owner == OWN_S);
          ram_addr_d  = addr_q;
          ram_wdata_d = (owner == OWN_S) ? wdata_q : '0;
        end
      end

      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      lat_cnt      <= '0;
      starve_cnt   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      oRAM_CE      <= 1'b0;
      oRAM_RD      <= 1'b0;
      oRAM_WR      <= 1'b0;
      oRAM_ADDR    <= '0;
      oRAM_DATA_WR <= '0;
      oDONE_F      <= 1'b0;
      oDONE_L      <= 1'b0;
      oDONE_S      <= 1'b0;
      oRDATA       <= '0;
      oBUSY        <= 1'b0;
    end else begin
      state        <= state_d;
      owner        <= owner_d;
      lat_cnt      <= lat_d;
      starve_cnt   <= starve_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      oRAM_CE      <= ce_d;
      oRAM_RD      <= rd_d;
      oRAM_WR      <= wr_d;
      oRAM_ADDR    <= ram_addr_d;
      oRAM_DATA_WR <= ram_wdata_d;
      oDONE_F      <= done_f_d;
      oDONE_L      <= done_l_d;
      oDONE_S      <= done_s_d;
      oRDATA       <= rdata_d;
      oBUSY        <= busy_d;
    end
  end

endmodule
